// File: rtl/fifo_monitor_if.sv
// Observed FIFO handshake bundle: enables, data buses and status flags.
// The monitor only listens; the driving side (FIFO/stimulus) uses master.
interface fifo_monitor_if #(
    parameter int FIFO_WIDTH = 32
);
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;

    modport master (output wr_en, rd_en, data_in, data_out, empty, full);
    modport slave  (input  wr_en, rd_en, data_in, data_out, empty, full);
endinterface

// File: rtl/fifo_monitor.sv
// FIFO protocol monitor: shadow FIFO model that checks flags, read data and
// enable legality, reporting per-cycle pulses, sticky bits and a saturating count.
module fifo_monitor #(
    parameter int FIFO_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int ALLOW_SIMUL  = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    fifo_monitor_if.slave                 bus,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [$clog2(FIFO_DEPTH):0]   peak_occupancy,
    output logic [5:0]                    err_pulse,
    output logic [5:0]                    err_sticky,
    output logic [CNT_WIDTH-1:0]          err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [OW-1:0]         r_count;
    logic [OW-1:0]         r_peak;
    logic [FIFO_WIDTH-1:0] r_exp;
    logic                  r_pend;
    logic [5:0]            r_pulse;
    logic [5:0]            r_sticky;
    logic [CNT_WIDTH-1:0]  r_err_cnt;

    logic                  w_is_full;
    logic                  w_is_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [OW-1:0]         w_next_count;
    logic                  w_data_err;
    logic [5:0]            w_err;

    // Acceptance follows the shadow count, never the observed flags.
    assign w_is_full  = (r_count == OW'(FIFO_DEPTH));
    assign w_is_empty = (r_count == '0);
    assign w_push     = bus.wr_en && !w_is_full;
    assign w_pop      = bus.rd_en && !w_is_empty;

    always_comb begin
        w_next_count = r_count;
        if (w_push && !w_pop)
            w_next_count = r_count + OW'(1);
        else if (w_pop && !w_push)
            w_next_count = r_count - OW'(1);
    end

    always_comb begin
        w_data_err = 1'b0;
        if (READ_LATENCY == 0)
            w_data_err = w_pop && (bus.data_out != r_mem[r_rd_ptr]);
        else
            w_data_err = r_pend && (bus.data_out != r_exp);
    end

    assign w_err = {
        (ALLOW_SIMUL == 0) && bus.wr_en && bus.rd_en,
        w_data_err,
        bus.empty != w_is_empty,
        bus.full  != w_is_full,
        bus.rd_en && w_is_empty,
        bus.wr_en && w_is_full
    };

    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_peak    <= '0;
            r_exp     <= '0;
            r_pend    <= 1'b0;
            r_pulse   <= '0;
            r_sticky  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_next_count;
            if (w_next_count > r_peak)
                r_peak <= w_next_count;
            // Registered head word is only consulted in the one-cycle-latency build.
            r_pend <= w_pop;
            if (w_pop)
                r_exp <= r_mem[r_rd_ptr];
            r_pulse  <= w_err;
            r_sticky <= r_sticky | w_err;
            if (|w_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end

    assign occupancy      = r_count;
    assign peak_occupancy = r_peak;
    assign err_pulse      = r_pulse;
    assign err_sticky     = r_sticky;
    assign err_count      = r_err_cnt;
endmodule

// File: tb/tb_fifo_monitor.sv
// Directed bench for fifo_monitor: a depth-16 / latency-1 / strict instance and a
// depth-4 / latency-0 / simultaneous-allowed / 4-bit-counter instance.
module tb_fifo_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, b_rst;
    logic [4:0]  a_occ, a_peak;
    logic [5:0]  a_pulse, a_sticky;
    logic [15:0] a_cnt;
    logic [2:0]  b_occ, b_peak;
    logic [5:0]  b_pulse, b_sticky;
    logic [3:0]  b_cnt;

    fifo_monitor_if #(.FIFO_WIDTH(32)) ifa ();
    fifo_monitor_if #(.FIFO_WIDTH(32)) ifb ();

    fifo_monitor #(.FIFO_WIDTH(32), .FIFO_DEPTH(16), .READ_LATENCY(1),
                   .ALLOW_SIMUL(0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(a_rst), .bus(ifa.slave),
        .occupancy(a_occ), .peak_occupancy(a_peak), .err_pulse(a_pulse),
        .err_sticky(a_sticky), .err_count(a_cnt));

    fifo_monitor #(.FIFO_WIDTH(32), .FIFO_DEPTH(4), .READ_LATENCY(0),
                   .ALLOW_SIMUL(1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(b_rst), .bus(ifb.slave),
        .occupancy(b_occ), .peak_occupancy(b_peak), .err_pulse(b_pulse),
        .err_sticky(b_sticky), .err_count(b_cnt));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        r, wr, rd;
        logic [31:0] din, dout;
        logic        e, f;
        logic [5:0]  pulse;
        logic [2:0]  occ;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic r, wr, rd, input logic [31:0] din, dout,
                          input logic e, f);
        a_rst = r; ifa.wr_en = wr; ifa.rd_en = rd; ifa.data_in = din;
        ifa.data_out = dout; ifa.empty = e; ifa.full = f;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input vec_t v);
        b_rst = v.r; ifb.wr_en = v.wr; ifb.rd_en = v.rd; ifb.data_in = v.din;
        ifb.data_out = v.dout; ifb.empty = v.e; ifb.full = v.f;
        @(posedge clk); #1;
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        ifa.wr_en = 0; ifa.rd_en = 0; ifa.data_in = 0; ifa.data_out = 0; ifa.empty = 1; ifa.full = 0;
        ifb.wr_en = 0; ifb.rd_en = 0; ifb.data_in = 0; ifb.data_out = 0; ifb.empty = 1; ifb.full = 0;

        //                r  wr rd din      dout      e  f  pulse      occ
        tbl[0]  = '{1'b1, 0, 0, 32'h0,   32'h0,    1, 0, 6'b000000, 3'd0};
        tbl[1]  = '{1'b0, 1, 0, 32'hB1,  32'h0,    1, 0, 6'b000000, 3'd1};
        tbl[2]  = '{1'b0, 1, 0, 32'hB2,  32'h0,    0, 0, 6'b000000, 3'd2};
        tbl[3]  = '{1'b0, 1, 0, 32'hB3,  32'h0,    0, 0, 6'b000000, 3'd3};
        tbl[4]  = '{1'b0, 1, 1, 32'hB4,  32'hB1,   0, 0, 6'b000000, 3'd3};
        tbl[5]  = '{1'b0, 0, 1, 32'h0,   32'hB2,   0, 0, 6'b000000, 3'd2};
        tbl[6]  = '{1'b0, 0, 1, 32'h0,   32'hB3,   0, 0, 6'b000000, 3'd1};
        tbl[7]  = '{1'b0, 0, 1, 32'h0,   32'hB4,   0, 0, 6'b000000, 3'd0};
        tbl[8]  = '{1'b0, 1, 0, 32'hB5,  32'h0,    1, 0, 6'b000000, 3'd1};
        tbl[9]  = '{1'b0, 0, 1, 32'h0,   32'h55,   0, 0, 6'b010000, 3'd0};
        tbl[10] = '{1'b0, 0, 0, 32'h0,   32'h0,    1, 0, 6'b000000, 3'd0};
        tbl[11] = '{1'b0, 0, 0, 32'h0,   32'h0,    1, 1, 6'b000100, 3'd0};
        tbl[12] = '{1'b0, 1, 1, 32'hB6,  32'h0,    1, 0, 6'b000010, 3'd1};
        tbl[13] = '{1'b0, 0, 1, 32'h0,   32'hB6,   0, 0, 6'b000000, 3'd0};

        // ---------- instance A: depth 16, read latency 1, strict ----------
        step_a(1, 1, 0, 32'h7, 0, 1, 0);
        step_a(1, 1, 0, 32'h7, 0, 1, 0);
        chk("a_reset_occ", a_occ, 0);
        chk("a_reset_peak", a_peak, 0);
        chk("a_reset_pulse", a_pulse, 0);
        chk("a_reset_sticky", a_sticky, 0);
        chk("a_reset_cnt", a_cnt, 0);

        for (int i = 0; i < 16; i++) begin
            step_a(0, 1, 0, 32'(i + 1), 0, i == 0, 0);
            chk("a_fill_occ", a_occ, 32'(i + 1));
            chk("a_fill_pulse", a_pulse, 0);
        end
        chk("a_fill_peak", a_peak, 16);

        step_a(0, 1, 0, 32'h99, 0, 0, 1);
        chk("a_ovf_pulse", a_pulse, 6'b000001);
        chk("a_ovf_cnt", a_cnt, 1);
        chk("a_ovf_occ", a_occ, 16);
        step_a(0, 0, 0, 0, 0, 0, 1);
        chk("a_idle_pulse", a_pulse, 0);
        chk("a_idle_sticky", a_sticky, 6'b000001);

        for (int k = 0; k < 16; k++) begin
            step_a(0, 0, 1, 0, (k == 3) ? 32'hDEAD : 32'(k), 0, k == 0);
            chk("a_drain_pulse", a_pulse, (k == 3) ? 6'b010000 : 6'b000000);
            chk("a_drain_occ", a_occ, 32'(15 - k));
        end
        chk("a_drain_cnt", a_cnt, 2);
        step_a(0, 0, 0, 0, 32'h10, 1, 0);
        chk("a_last_data_pulse", a_pulse, 0);

        step_a(0, 0, 1, 0, 0, 1, 0);
        chk("a_unf_pulse", a_pulse, 6'b000010);
        chk("a_unf_occ", a_occ, 0);
        chk("a_unf_cnt", a_cnt, 3);

        for (int j = 0; j < 3; j++) begin
            step_a(0, 0, 0, 0, 0, 0, 0);
            chk("a_empty_bad_pulse", a_pulse, 6'b001000);
            chk("a_empty_bad_cnt", a_cnt, 32'(4 + j));
        end
        step_a(0, 0, 0, 0, 0, 1, 0);
        chk("a_release_pulse", a_pulse, 0);
        chk("a_release_sticky", a_sticky, 6'b011011);

        for (int i = 0; i < 5; i++)
            step_a(0, 1, 0, 32'(32'hA1 + i), 0, i == 0, 0);
        chk("a_pre_simul_occ", a_occ, 5);
        step_a(0, 1, 1, 32'hA6, 0, 0, 0);
        chk("a_simul_pulse", a_pulse, 6'b100000);
        chk("a_simul_occ", a_occ, 5);
        step_a(0, 0, 0, 0, 32'hA1, 0, 0);
        chk("a_simul_data_pulse", a_pulse, 0);
        chk("a_simul_cnt", a_cnt, 7);

        step_a(0, 0, 1, 0, 0, 0, 0);
        step_a(0, 0, 1, 0, 32'hA2, 0, 0);
        chk("a_order_pulse", a_pulse, 0);
        chk("a_pre_rst_occ", a_occ, 3);
        step_a(0, 0, 1, 0, 32'hA3, 0, 0);
        chk("a_order_pulse2", a_pulse, 0);
        step_a(1, 0, 0, 0, 32'hBAD, 0, 0);
        chk("a_midrst_occ", a_occ, 0);
        chk("a_midrst_peak", a_peak, 0);
        chk("a_midrst_pulse", a_pulse, 0);
        chk("a_midrst_sticky", a_sticky, 0);
        chk("a_midrst_cnt", a_cnt, 0);
        step_a(0, 0, 0, 0, 32'hBAD, 1, 0);
        chk("a_after_rst_pulse", a_pulse, 0);
        chk("a_after_rst_cnt", a_cnt, 0);
        a_rst = 1'b1;

        // ---------- instance B: depth 4, read latency 0, simultaneous legal ----------
        for (int i = 0; i < 14; i++) begin
            step_b(tbl[i]);
            chk($sformatf("b_vec%0d_pulse", i), b_pulse, tbl[i].pulse);
            chk($sformatf("b_vec%0d_occ", i), b_occ, tbl[i].occ);
        end
        chk("b_table_cnt", b_cnt, 3);
        chk("b_peak", b_peak, 3);

        for (int j = 0; j < 20; j++) begin
            step_b('{1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 6'b0, 3'd0});
            chk("b_sat_cnt", b_cnt, (4 + j > 15) ? 15 : 32'(4 + j));
        end
        chk("b_sat_pulse", b_pulse, 6'b001000);
        chk("b_sticky", b_sticky, 6'b011110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_monitor.md
# fifo_monitor

Parametrised, synthesizable FIFO protocol monitor and scoreboard that sits beside any FIFO instance in the design. It keeps a shadow model of occupancy and contents, and from that model it checks the FIFO's full/empty flags, its read data, and the legality of each enable. Violations appear as per-cycle error pulses, sticky error bits and a saturating error counter, so the block works both in simulation and on FPGA debug builds where SVA is unavailable.

## Interface
Parameters:
- FIFO_WIDTH, 32, data width in bits
- FIFO_DEPTH, 16, entries in the monitored FIFO (power of two, ≥2)
- READ_LATENCY, 1, cycles from accepted read to valid data_out (0 or 1 only)
- ALLOW_SIMUL, 0, 1 = simultaneous wr_en/rd_en is legal; 0 = flagged as error
- CNT_WIDTH, 16, width of error counter

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  FIFO write enable (observed)
- rd_en  input  1  FIFO read enable (observed)
- data_in  input  FIFO_WIDTH  FIFO write data (observed)
- data_out  input  FIFO_WIDTH  FIFO read data (observed)
- empty  input  1  FIFO empty flag (observed)
- full  input  1  FIFO full flag (observed)
- occupancy  output  $clog2(FIFO_DEPTH)+1  shadow entry count
- peak_occupancy  output  $clog2(FIFO_DEPTH)+1  highest occupancy since reset
- err_pulse  output  6  one-cycle error indication per check
- err_sticky  output  6  OR-accumulated err_pulse since reset
- err_count  output  CNT_WIDTH  total error events, saturating

## Operation
- Shadow model: FIFO_DEPTH x FIFO_WIDTH RAM, write pointer, read pointer, count. Pointers wrap modulo FIFO_DEPTH.
- Write is accepted when wr_en && count<FIFO_DEPTH. The shadow pushes data_in.
- Read is accepted when rd_en && count>0. The shadow pops the head entry, which becomes the expected data.
- Both accepted in one cycle: push and pop together, count unchanged. This applies even when ALLOW_SIMUL=0; the model stays in sync and the error is still flagged.
- Acceptance uses the shadow count, not the DUT flags. Flag disagreement is reported separately.
- Error bits (index: condition evaluated in cycle N):
  - 0 OVERFLOW: wr_en && count==FIFO_DEPTH (no push)
  - 1 UNDERFLOW: rd_en && count==0 (no pop, no data compare)
  - 2 FULL_MISMATCH: full != (count==FIFO_DEPTH)
  - 3 EMPTY_MISMATCH: empty != (count==0)
  - 4 DATA_MISMATCH: data_out != expected at the compare cycle
  - 5 SIMUL: wr_en && rd_en && ALLOW_SIMUL==0
- err_count increments by 1 per cycle in which any err_pulse bit is set, not per bit. It holds at 2^CNT_WIDTH-1.
- peak_occupancy updates to the new count whenever the new count exceeds it.

## Timing
- All outputs are registered. Reset values: occupancy=0, peak_occupancy=0, err_pulse=0, err_sticky=0, err_count=0. Pointers and pending-compare state are cleared. RAM contents are don't-care.
- While rst=1, no checks run, err_pulse stays 0 and enables are ignored. The first checked cycle is the first rising edge with rst=0.
- Flag checks in cycle N compare the DUT flags with the count held at the start of cycle N, i.e. the pre-operation state.
- A violation detected in cycle N drives err_pulse high in cycle N+1. err_sticky and err_count update in the same cycle N+1.
- READ_LATENCY=0: data_out is compared in cycle N, the read cycle, against the head entry. Result appears in err_pulse[4] at N+1.
- READ_LATENCY=1: the expected word and a pending bit are registered at N. data_out is compared at N+1. Result appears in err_pulse[4] at N+2.
- Reset asserted while a compare is pending: the pending bit is cleared and no compare happens.
- occupancy reflects the post-operation count one cycle after the operation.

## Test plan
- Reset then fill: write 0x1..0x10 with DEPTH=16 and a correct DUT -> occupancy reaches 16 and peak_occupancy=16. One more wr_en -> err_pulse=6'b000001 next cycle, err_count=1, occupancy stays 16.
- Drain with READ_LATENCY=1: 16 reads -> data_out 0x1..0x10 accepted with no errors. A 17th rd_en -> err_pulse[1]=1. Force data_out=0xDEAD on the 3rd read -> err_pulse[4]=1 two cycles after that rd_en.
- Flag corruption: hold empty=0 at count 0 -> err_pulse[3]=1 every cycle, err_count increments every cycle. Release -> err_sticky[3] stays 1.
- Simultaneous access at count 5 with ALLOW_SIMUL=0 -> err_pulse[5]=1 and occupancy stays 5. With ALLOW_SIMUL=1 -> no error, occupancy 5, data order preserved.
- Reset mid-read: rd_en at count 3 with READ_LATENCY=1, rst=1 on the next edge -> no err_pulse[4]. All outputs read 0 after reset.
- Saturation with CNT_WIDTH=4: 20 error cycles -> err_count=15 and stays 15.
